reg_dump_sequencer: RTL and testbench

Sequencer that walks the register file (x0–x31 plus pc) and writes a formatted text dump into the ASCII character buffer that feeds the VGA debug display. It snapshots one register at a time through a read port, converts it to decimal with a multi-cycle shift-and-add-3 converter, and streams the label and digit characters into the character buffer's write port. It sits between the CPU register file / pc and the ASCII display controller, and is the only writer of the debug text area.

---
 rtl/debug_pkg.sv | 39 +++
 rtl/bin2bcd_seq.sv | 55 +++++
 rtl/reg_dump_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_reg_dump_sequencer.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the register-dump debug text path.
//   state_e       : dump sequencer states
//   NUM_ROWS      : rows in a dump (x0..x31 plus pc)
//   PC_ROW        : row index that shows the pc
//   ASCII_*       : character codes used to build a row
//   LABEL_W       : label columns before the value digits
//   digit_char()  : 4-bit value to '0'..'9' / 'A'..'F'
// -----------------------------------------------------------------------------
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CONV = 3'd2,
        EMIT = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } state_e;

    localparam int NUM_ROWS = 33;
    localparam int PC_ROW   = 32;
    localparam int LABEL_W  = 4;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_X       = 8'h78;
    localparam logic [7:0] ASCII_P       = 8'h70;
    localparam logic [7:0] ASCII_C       = 8'h63;

    // Decimal digits never exceed 9, so the same mapping serves both formats.
    function automatic logic [7:0] digit_char(input logic [3:0] n);
        if (n < 4'd10) return ASCII_ZERO + {4'd0, n};
        else           return ASCII_UPPER_A + {4'd0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble: 32-bit binary to 10-digit BCD in 32 cycles.
//   clk, rst : clock, asynchronous active-low reset
//   start    : load bin_in and begin converting (one cycle)
//   bin_in   : value to convert, captured on the start cycle (acts as snapshot)
//   done     : high during the final shift cycle; bcd is valid from the
//              next cycle on and stays stable until the next start
//   bcd      : 10 BCD digits, digit 9 in bcd[39:36]
// -----------------------------------------------------------------------------
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bin_in,
    output logic        done,
    output logic [39:0] bcd
);

    logic [31:0] bin_q;
    logic [39:0] bcd_q;
    logic [4:0]  cnt_q;
    logic        active_q;
    logic [39:0] adj;

    // Add 3 to every nibble >= 5 so the following shift carries correctly.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            bin_q    <= bin_in;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            {bcd_q, bin_q} <= {adj, bin_q} << 1;
            cnt_q          <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) active_q <= 1'b0;
        end
    end

    assign done = active_q && (cnt_q == 5'd31);
    assign bcd  = bcd_q;

endmodule

// File: rtl/reg_dump_sequencer.sv
// -----------------------------------------------------------------------------
// reg_dump_sequencer
// Walks x0..x31 and pc, formats each as one text row and writes the characters
// into the VGA debug character buffer.
//
// Row layout: cols 0-3 label ("x05 " / "pc  "), then the value.
//   default build     : 10 decimal digits, cols 4-13, via bin2bcd_seq
//   DBG_HEX_EN defined: 8 uppercase hex digits, cols 4-11, no conversion state
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   start               : one-cycle frame request
//   reg_rd_addr         : register row being read (32 = pc)
//   reg_rd_data         : combinational read data for reg_rd_addr
//   ascii_ready         : buffer accepts a character this cycle
//   ascii_write_en      : character valid
//   ascii_input         : character code
//   ascii_write_address : row*COLS + col
//   busy                : frame dump in progress
//   frame_done          : one-cycle pulse after the last character
//   dbg_state           : current FSM state (debug_pkg::state_e encoding)
//
// Write handshake: a character transfers on a rising edge where
// ascii_write_en && ascii_ready. Once ascii_write_en is raised, it and the
// character/address stay unchanged until that transfer happens.
//
// A trigger (start or refresh tick) while busy is remembered in a single
// pending flag; the next frame then starts straight out of DONE.
// -----------------------------------------------------------------------------
module reg_dump_sequencer
    import debug_pkg::*;
#(
    parameter int COLS           = 80,
    parameter int ADDR_W         = 13,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [5:0]        reg_rd_addr,
    input  logic [31:0]       reg_rd_data,
    input  logic              ascii_ready,
    output logic              ascii_write_en,
    output logic [7:0]        ascii_input,
    output logic [ADDR_W-1:0] ascii_write_address,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE = 3'(IDLE);
    localparam logic [2:0] S_LOAD = 3'(LOAD);
    localparam logic [2:0] S_CONV = 3'(CONV);
    localparam logic [2:0] S_EMIT = 3'(EMIT);
    localparam logic [2:0] S_NEXT = 3'(NEXT);
    localparam logic [2:0] S_DONE = 3'(DONE);

`ifdef DBG_HEX_EN
    localparam int DIGITS = 8;
`else
    localparam int DIGITS = 10;
`endif
    localparam logic [3:0] LAST_COL = 4'(LABEL_W + DIGITS - 1);
    localparam logic [5:0] LAST_ROW = 6'(PC_ROW);

    // The bottom-right character of the pc row must be addressable.
    generate
        if (COLS * NUM_ROWS > (1 << ADDR_W)) begin : g_addr_check
            $error("reg_dump_sequencer: COLS*33 does not fit in ADDR_W bits");
        end
    endgenerate

    logic [2:0] state_q;
    logic [5:0] row_q;
    logic [3:0] col_q;
    logic       pending_q;
    logic       refresh_tick;
    logic       trigger;
    logic       conv_done;
    logic [7:0] ch;
    logic [3:0] vdig;
    logic [5:0] row_tens;
    logic [5:0] row_ones;

    // ---------------------------------------------------------------- refresh
    generate
        if (REFRESH_CYCLES == 0) begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end else begin : g_refresh
            localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)                 cnt_q <= '0;
                else if (cnt_q == CNT_LAST) cnt_q <= '0;
                else                      cnt_q <= cnt_q + CNT_W'(1);
            end

            assign refresh_tick = (cnt_q == CNT_LAST);
        end
    endgenerate

    assign trigger = start | refresh_tick;

    // ---------------------------------------------------------- value source
`ifdef DBG_HEX_EN
    logic [31:0] snap_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  snap_q <= '0;
        else if (state_q == S_LOAD) snap_q <= reg_rd_data;
    end

    assign conv_done = 1'b1;

    always_comb begin
        vdig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (col_q == 4'(LABEL_W + i)) vdig = snap_q[(DIGITS-1-i)*4 +: 4];
        end
    end
`else
    logic [39:0] bcd;

    // The converter's input register is the per-row snapshot.
    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (state_q == S_LOAD),
        .bin_in (reg_rd_data),
        .done   (conv_done),
        .bcd    (bcd)
    );

    always_comb begin
        vdig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (col_q == 4'(LABEL_W + i)) vdig = bcd[(DIGITS-1-i)*4 +: 4];
        end
    end
`endif

    // -------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_q <= S_LOAD;
                        row_q   <= '0;
                    end
                end
                S_LOAD: begin
                    col_q <= '0;
`ifdef DBG_HEX_EN
                    state_q <= S_EMIT;
`else
                    state_q <= S_CONV;
`endif
                end
                S_CONV: begin
                    if (conv_done) state_q <= S_EMIT;
                end
                S_EMIT: begin
                    if (ascii_ready) begin
                        if (col_q == LAST_COL) state_q <= S_NEXT;
                        else                   col_q   <= col_q + 4'd1;
                    end
                end
                S_NEXT: begin
                    if (row_q == LAST_ROW) begin
                        state_q <= S_DONE;
                    end else begin
                        row_q   <= row_q + 6'd1;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    // A trigger landing in DONE itself is folded into the restart.
                    row_q     <= '0;
                    pending_q <= 1'b0;
                    state_q   <= (pending_q || trigger) ? S_LOAD : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (trigger && (state_q != S_IDLE) && (state_q != S_DONE)) pending_q <= 1'b1;
        end
    end

    // ----------------------------------------------------------- characters
    assign row_tens = row_q / 6'd10;
    assign row_ones = row_q % 6'd10;

    always_comb begin
        ch = ASCII_SPACE;
        case (col_q)
            4'd0:    ch = (row_q == LAST_ROW) ? ASCII_P : ASCII_X;
            4'd1:    ch = (row_q == LAST_ROW) ? ASCII_C : ASCII_ZERO + {2'b00, row_tens};
            4'd2:    ch = (row_q == LAST_ROW) ? ASCII_SPACE : ASCII_ZERO + {2'b00, row_ones};
            4'd3:    ch = ASCII_SPACE;
            default: ch = digit_char(vdig);
        endcase
    end

    // Outputs are decoded from registered state so reset clears them at once.
    assign ascii_write_en      = (state_q == S_EMIT);
    assign ascii_input         = (state_q == S_EMIT) ? ch : 8'd0;
    assign ascii_write_address = (state_q == S_EMIT)
                               ? ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q)
                               : '0;
    assign reg_rd_addr         = row_q;
    assign busy                = (state_q != S_IDLE);
    assign frame_done          = (state_q == S_DONE);
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
module tb_reg_dump_sequencer;
    import debug_pkg::*;

    localparam int COLS   = 80;
    localparam int ADDR_W = 13;
`ifdef DBG_HEX_EN
    localparam int CHARS   = 12;
    localparam int ROW_CYC = 1 + CHARS + 1;
`else
    localparam int CHARS   = 14;
    localparam int ROW_CYC = 1 + 32 + CHARS + 1;
`endif
    localparam int FRAME_CYC = NUM_ROWS * ROW_CYC;
    localparam int WRITES    = NUM_ROWS * CHARS;

    // ------------------------------------------------------------ clock/reset
    logic clk;
    logic rst;
    logic rst_r;
    logic start;
    logic ascii_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------- DUT
    logic [31:0]       regs [0:32];
    logic [5:0]        reg_rd_addr;
    logic [31:0]       reg_rd_data;
    logic              ascii_write_en;
    logic [7:0]        ascii_input;
    logic [ADDR_W-1:0] ascii_write_address;
    logic              busy;
    logic              frame_done;
    logic [2:0]        dbg_state;

    assign reg_rd_data = (reg_rd_addr <= 6'd32) ? regs[reg_rd_addr] : 32'h0;

    reg_dump_sequencer #(.COLS(COLS), .ADDR_W(ADDR_W), .REFRESH_CYCLES(0)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .reg_rd_addr         (reg_rd_addr),
        .reg_rd_data         (reg_rd_data),
        .ascii_ready         (ascii_ready),
        .ascii_write_en      (ascii_write_en),
        .ascii_input         (ascii_input),
        .ascii_write_address (ascii_write_address),
        .busy                (busy),
        .frame_done          (frame_done),
        .dbg_state           (dbg_state)
    );

    // Second instance only exercises the auto-refresh timer.
    logic [5:0]        r_rd_addr;
    logic              r_we;
    logic [7:0]        r_ch;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;
    logic [2:0]        r_state;

    reg_dump_sequencer #(.COLS(COLS), .ADDR_W(ADDR_W), .REFRESH_CYCLES(100)) u_dut_refresh (
        .clk                 (clk),
        .rst                 (rst_r),
        .start               (1'b0),
        .reg_rd_addr         (r_rd_addr),
        .reg_rd_data         (32'h0),
        .ascii_ready         (1'b1),
        .ascii_write_en      (r_we),
        .ascii_input         (r_ch),
        .ascii_write_address (r_addr),
        .busy                (r_busy),
        .frame_done          (r_done),
        .dbg_state           (r_state)
    );

    // ------------------------------------------------------- bookkeeping
    int tests_run = 0;
    int fails     = 0;
    int writes    = 0;
    int done_pulses = 0;
    int cyc       = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: held low

    logic [ADDR_W+7:0] exp_q [$];
    logic [ADDR_W+7:0] mon_exp;
    logic [7:0]        screen [0:(1<<ADDR_W)-1];
    logic              stall_prev = 1'b0;
    logic [ADDR_W+8:0] stall_val;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ascii_ready = 1'b1;
            1:       ascii_ready = ($urandom_range(0, 3) != 0);
            default: ascii_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------ reference
    function automatic logic [7:0] model_char(input int row, input int col, input logic [31:0] v);
        longint unsigned val;
        longint unsigned p;
        int d;
        int n;
        val = 64'(v);
        if (col == 0) return (row == 32) ? 8'h70 : 8'h78;
        if (col == 1) return (row == 32) ? 8'h63 : 8'(48 + row / 10);
        if (col == 2) return (row == 32) ? 8'h20 : 8'(48 + row % 10);
        if (col == 3) return 8'h20;
        d = col - 4;
`ifdef DBG_HEX_EN
        n = int'((val >> (4 * (7 - d))) & 64'hF);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
`else
        p = 1;
        for (int k = 0; k < 9 - d; k++) p = p * 10;
        n = int'((val / p) % 10);
        return 8'(48 + n);
`endif
    endfunction

    task automatic build_frame();
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < CHARS; c++)
                exp_q.push_back({ADDR_W'(r * COLS + c), model_char(r, c, regs[r])});
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 33; i++) regs[i] = $urandom;
    endtask

    // ----------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev) begin
                tests_run++;
                if ({ascii_write_en, ascii_write_address, ascii_input} !== stall_val) begin
                    fails++;
                    $display("FAIL stall_hold: got %h, required %h",
                             {ascii_write_en, ascii_write_address, ascii_input}, stall_val);
                end
            end
            stall_prev = ascii_write_en && !ascii_ready;
            stall_val  = {ascii_write_en, ascii_write_address, ascii_input};
            if (frame_done) done_pulses++;
            if (ascii_write_en && ascii_ready) begin
                writes++;
                screen[ascii_write_address] = ascii_input;
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected: got addr=%0d char=%02h, required no write",
                             ascii_write_address, ascii_input);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({ascii_write_address, ascii_input} !== mon_exp) begin
                        fails++;
                        $display("FAIL write: got addr=%0d char=%02h, required addr=%0d char=%02h",
                                 ascii_write_address, ascii_input,
                                 mon_exp[ADDR_W+7:8], mon_exp[7:0]);
                    end
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // --------------------------------------------------------------- driver
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            tests_run++;
            fails++;
            $display("FAIL frame_done_timeout: got no frame_done, required within %0d cycles", limit);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        start = 1'b0;
        rst_r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({ascii_write_en, ascii_input, ascii_write_address, busy, frame_done, reg_rd_addr, dbg_state} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got we=%b ch=%02h addr=%0d busy=%b done=%b rd=%0d st=%0d, required all 0",
                     ascii_write_en, ascii_input, ascii_write_address, busy, frame_done, reg_rd_addr, dbg_state);
        end
        @(negedge clk) rst = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || writes != 0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b writes=%0d, required busy=0 writes=0", busy, writes);
        end
    endtask

    task automatic test_single_frame();
        int t0;
        bit ok;
        int rows [4];
        string strs [4];
        string s;
        randomize_regs();
        regs[0] = 32'd0;  regs[5] = 32'd123;  regs[10] = 32'hDEADBEEF;  regs[32] = 32'hFFFFFFFF;
        rows = '{0, 5, 10, 32};
`ifdef DBG_HEX_EN
        strs = '{"x00 00000000", "x05 0000007B", "x10 DEADBEEF", "pc  FFFFFFFF"};
`else
        strs = '{"x00 0000000000", "x05 0000000123", "x10 3735928559", "pc  4294967295"};
`endif
        for (int i = 0; i < (1 << ADDR_W); i++) screen[i] = 8'h00;
        exp_q.delete();
        build_frame();
        writes = 0;
        done_pulses = 0;
        pulse_start();
        t0 = cyc;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || dbg_state !== 3'(LOAD) || reg_rd_addr !== 6'd0) begin
            fails++;
            $display("FAIL start_to_load: got busy=%b st=%0d rd=%0d, required busy=1 st=%0d rd=0",
                     busy, dbg_state, reg_rd_addr, 3'(LOAD));
        end
        wait_done(FRAME_CYC + 100, ok);
        if (ok) begin
            tests_run++;
            if (cyc - t0 != FRAME_CYC) begin
                fails++;
                $display("FAIL frame_time: got %0d cycles, required %0d", cyc - t0, FRAME_CYC);
            end
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done_pulses != 1 || writes != WRITES || exp_q.size() != 0) begin
            fails++;
            $display("FAIL frame_end: got busy=%b done=%0d writes=%0d left=%0d, required busy=0 done=1 writes=%0d left=0",
                     busy, done_pulses, writes, exp_q.size(), WRITES);
        end
        for (int k = 0; k < 4; k++) begin
            s = strs[k];
            for (int c = 0; c < CHARS; c++) begin
                tests_run++;
                if (screen[rows[k] * COLS + c] !== s[c]) begin
                    fails++;
                    $display("FAIL row_text: row %0d col %0d got %02h, required %02h",
                             rows[k], c, screen[rows[k] * COLS + c], s[c]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int t0;
        int n;
        bit ok;
        randomize_regs();
        exp_q.delete();
        build_frame();
        writes = 0;
        pulse_start();
        t0 = cyc;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (ascii_write_en && ascii_ready && ascii_write_address == ADDR_W'(5)) break;
            n++;
        end
        ready_mode = 2;
        @(negedge clk);
        tests_run++;
        if (ascii_write_en !== 1'b1 || ascii_write_address !== ADDR_W'(6) || ascii_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_position: got we=%b addr=%0d ready=%b, required we=1 addr=6 ready=0",
                     ascii_write_en, ascii_write_address, ascii_ready);
        end
        repeat (9) @(negedge clk);
        ready_mode = 0;
        wait_done(FRAME_CYC + 200, ok);
        if (ok) begin
            tests_run++;
            if (cyc - t0 != FRAME_CYC + 10) begin
                fails++;
                $display("FAIL stall_frame_time: got %0d cycles, required %0d", cyc - t0, FRAME_CYC + 10);
            end
        end
        @(negedge clk);
        tests_run++;
        if (writes != WRITES || exp_q.size() != 0) begin
            fails++;
            $display("FAIL stall_writes: got writes=%0d left=%0d, required writes=%0d left=0",
                     writes, exp_q.size(), WRITES);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        randomize_regs();
        exp_q.delete();
        build_frame();
        writes = 0;
        ready_mode = 1;
        pulse_start();
        wait_done(4 * FRAME_CYC, ok);
        ready_mode = 0;
        @(negedge clk);
        tests_run++;
        if (writes != WRITES || exp_q.size() != 0) begin
            fails++;
            $display("FAIL backpressure_writes: got writes=%0d left=%0d, required writes=%0d left=0",
                     writes, exp_q.size(), WRITES);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        bit ok;
        randomize_regs();
        exp_q.delete();
        build_frame();
        build_frame();
        writes = 0;
        done_pulses = 0;
        pulse_start();
        t0 = cyc;
        repeat (498) @(posedge clk);
        pulse_start();   // lands mid-frame: becomes pending
        pulse_start();   // pending already set: dropped
        wait_done(FRAME_CYC + 100, ok);
        t1 = cyc;
        if (ok) begin
            tests_run++;
            if (t1 - t0 != FRAME_CYC) begin
                fails++;
                $display("FAIL pending_frame1_time: got %0d cycles, required %0d", t1 - t0, FRAME_CYC);
            end
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || dbg_state !== 3'(LOAD) || reg_rd_addr !== 6'd0) begin
            fails++;
            $display("FAIL pending_restart: got busy=%b st=%0d rd=%0d, required busy=1 st=%0d rd=0",
                     busy, dbg_state, reg_rd_addr, 3'(LOAD));
        end
        wait_done(FRAME_CYC + 100, ok);
        if (ok) begin
            tests_run++;
            if (cyc - t1 != FRAME_CYC + 1) begin
                fails++;
                $display("FAIL pending_frame2_time: got %0d cycles, required %0d", cyc - t1, FRAME_CYC + 1);
            end
        end
        repeat (30) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done_pulses != 2 || writes != 2 * WRITES || exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_end: got busy=%b done=%0d writes=%0d left=%0d, required busy=0 done=2 writes=%0d left=0",
                     busy, done_pulses, writes, exp_q.size(), 2 * WRITES);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit ok;
        logic [2:0] target;
`ifdef DBG_HEX_EN
        target = 3'(EMIT);
`else
        target = 3'(CONV);
`endif
        randomize_regs();
        exp_q.delete();
        build_frame();
        pulse_start();
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (reg_rd_addr == 6'd10 && dbg_state == target) break;
            n++;
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({ascii_write_en, ascii_input, ascii_write_address, busy, frame_done, reg_rd_addr, dbg_state} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got we=%b ch=%02h addr=%0d busy=%b done=%b rd=%0d st=%0d, required all 0",
                     ascii_write_en, ascii_input, ascii_write_address, busy, frame_done, reg_rd_addr, dbg_state);
        end
        exp_q.delete();
        writes = 0;
        done_pulses = 0;
        @(negedge clk) rst = 1'b1;
        repeat (100) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || writes != 0 || done_pulses != 0) begin
            fails++;
            $display("FAIL reset_mid_quiet: got busy=%b writes=%0d done=%0d, required 0 0 0",
                     busy, writes, done_pulses);
        end
        build_frame();
        pulse_start();
        wait_done(FRAME_CYC + 100, ok);
        @(negedge clk);
        tests_run++;
        if (writes != WRITES || exp_q.size() != 0) begin
            fails++;
            $display("FAIL reset_recover: got writes=%0d left=%0d, required writes=%0d left=0",
                     writes, exp_q.size(), WRITES);
        end
    endtask

    task automatic test_refresh();
        int n;
        n = 0;
        @(negedge clk) rst_r = 1'b1;
        while (n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (r_busy) break;
        end
        tests_run++;
        if (n != 100 || r_state !== 3'(LOAD) || r_rd_addr !== 6'd0) begin
            fails++;
            $display("FAIL refresh_start: got cycle=%0d st=%0d rd=%0d, required cycle=100 st=%0d rd=0",
                     n, r_state, r_rd_addr, 3'(LOAD));
        end
        rst_r = 1'b0;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        start = 1'b0;
        rst_r = 1'b0;
        for (int i = 0; i < 33; i++) regs[i] = 32'h0;
        test_reset();
        test_single_frame();
        test_stall();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_refresh();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
